// File: rtl/router_pkg.sv
// Shared definitions for the deflection router: flit field layout, port
// indices and direction encodings.
package router_pkg;

    localparam int FLIT_W    = 11;
    localparam int NPORTS    = 4;
    localparam int VALID_BIT = 10;
    localparam int MASK_HI   = 9;
    localparam int MASK_LO   = 6;
    localparam int DX_HI     = 5;
    localparam int DX_LO     = 3;
    localparam int DY_HI     = 2;
    localparam int DY_LO     = 0;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_S = 2'd1,
        PORT_E = 2'd2,
        PORT_W = 2'd3
    } port_e;

    // Productive-mask encoding as carried in flit bits [9:6] ({N,S,E,W})
    localparam logic [3:0] DIR_N = 4'b1000;
    localparam logic [3:0] DIR_S = 4'b0100;
    localparam logic [3:0] DIR_E = 4'b0010;
    localparam logic [3:0] DIR_W = 4'b0001;

    // Reorder a {N,S,E,W} mask into a vector indexed by port_e
    function automatic logic [3:0] mask_to_ports(input logic [3:0] mask);
        logic [3:0] p;
        p[PORT_N] = |(mask & DIR_N);
        p[PORT_S] = |(mask & DIR_S);
        p[PORT_E] = |(mask & DIR_E);
        p[PORT_W] = |(mask & DIR_W);
        return p;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/route_arb_stage_if.sv
// Flit bus between the input pipeline stage and the route/arbitration stage.
interface route_arb_stage_if;
    import router_pkg::*;

    logic [FLIT_W-1:0] noin, soin, eoin, woin;
    logic [FLIT_W-1:0] nout, sout, eout, wout, eject;
    logic [3:0]        defl;

    modport master (
        output noin, soin, eoin, woin,
        input  nout, sout, eout, wout, eject, defl
    );

    modport slave (
        input  noin, soin, eoin, woin,
        output nout, sout, eout, wout, eject, defl
    );

endinterface

// File: rtl/route_arb_stage_route_compute.sv
// Per-flit route computation: validity, local-destination flag and the
// {N,S,E,W} productive-direction mask relative to this router.
module route_compute
    import router_pkg::*;
#(
    parameter logic [2:0] MY_X = 3'd2,
    parameter logic [2:0] MY_Y = 3'd2
) (
    input  logic [FLIT_W-1:0] flit,
    output logic              valid,
    output logic              local_dst,
    output logic [3:0]        mask
);

    logic [2:0] dx, dy;

    assign dx        = flit[DX_HI:DX_LO];
    assign dy        = flit[DY_HI:DY_LO];
    assign valid     = flit[VALID_BIT];
    assign mask      = {dy > MY_Y, dy < MY_Y, dx > MY_X, dx < MY_X};
    assign local_dst = (mask == '0);

endmodule

// File: rtl/route_arb_stage.sv
// Route computation, single-flit ejection and golden-priority deflection
// arbitration with registered outputs. Optional ROUTE_STATS_EN adds defl_cnt.
module route_arb_stage
    import router_pkg::*;
#(
    parameter int unsigned MY_X          = 2,
    parameter int unsigned MY_Y          = 2,
    parameter int unsigned GOLDEN_PERIOD = 8
) (
    input  logic              clk,
    input  logic              rst,
    route_arb_stage_if.slave  bus
`ifdef ROUTE_STATS_EN
    ,
    output logic [15:0]       defl_cnt
`endif
);

    localparam int unsigned CNT_W = (GOLDEN_PERIOD > 1) ? $clog2(GOLDEN_PERIOD) : 1;

    logic [FLIT_W-1:0] fin     [NPORTS];
    logic [3:0]        msk     [NPORTS];
    logic [NPORTS-1:0] vld, loc;

    logic [FLIT_W-1:0] nxt_out [NPORTS];
    logic [FLIT_W-1:0] out_q   [NPORTS];
    logic [FLIT_W-1:0] nxt_ej, ej_q;
    logic [3:0]        nxt_defl, defl_q;

    logic [1:0]        g;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        idx;
    port_e             pick;
    logic              found, dfl, ejected;
    logic [3:0]        prod, free;

    assign fin[PORT_N] = bus.noin;
    assign fin[PORT_S] = bus.soin;
    assign fin[PORT_E] = bus.eoin;
    assign fin[PORT_W] = bus.woin;

    for (genvar i = 0; i < NPORTS; i++) begin : g_rc
        route_compute #(
            .MY_X(3'(MY_X)),
            .MY_Y(3'(MY_Y))
        ) u_rc (
            .flit      (fin[i]),
            .valid     (vld[i]),
            .local_dst (loc[i]),
            .mask      (msk[i])
        );
    end

    // Walk inputs in golden order; each flit claims a port before the next looks
    always_comb begin
        free     = '1;
        nxt_defl = '0;
        nxt_ej   = '0;
        ejected  = 1'b0;
        idx      = '0;
        pick     = PORT_N;
        found    = 1'b0;
        dfl      = 1'b0;
        prod     = '0;
        for (int unsigned p = 0; p < NPORTS; p++) nxt_out[p] = '0;

        for (int unsigned k = 0; k < NPORTS; k++) begin
            idx   = g + k[1:0];
            prod  = mask_to_ports(msk[idx]);
            found = 1'b0;
            dfl   = 1'b0;
            pick  = PORT_N;
            if (vld[idx]) begin
                if (loc[idx] && !ejected) begin
                    nxt_ej  = {1'b1, 4'b0000, fin[idx][DX_HI:DY_LO]};
                    ejected = 1'b1;
                end else begin
                    if (prod[PORT_E] && free[PORT_E]) begin
                        pick = PORT_E; found = 1'b1;
                    end else if (prod[PORT_W] && free[PORT_W]) begin
                        pick = PORT_W; found = 1'b1;
                    end else if (prod[PORT_N] && free[PORT_N]) begin
                        pick = PORT_N; found = 1'b1;
                    end else if (prod[PORT_S] && free[PORT_S]) begin
                        pick = PORT_S; found = 1'b1;
                    end else begin
                        for (int unsigned j = 0; j < NPORTS; j++) begin
                            if (!found && free[j]) begin
                                pick  = port_e'(j[1:0]);
                                found = 1'b1;
                                dfl   = 1'b1;
                            end
                        end
                    end
                    if (found) begin
                        nxt_out[pick]  = {1'b1, msk[idx], fin[idx][DX_HI:DY_LO]};
                        free[pick]     = 1'b0;
                        nxt_defl[pick] = dfl;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < NPORTS; p++) out_q[p] <= '0;
            ej_q   <= '0;
            defl_q <= '0;
            g      <= '0;
            cnt    <= '0;
        end else begin
            for (int unsigned p = 0; p < NPORTS; p++) out_q[p] <= nxt_out[p];
            ej_q   <= nxt_ej;
            defl_q <= nxt_defl;
            if (cnt == CNT_W'(GOLDEN_PERIOD - 1)) begin
                cnt <= '0;
                g   <= g + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef ROUTE_STATS_EN
    logic [16:0] cnt_sum;

    assign cnt_sum = {1'b0, defl_cnt} + 17'(popcount4(nxt_defl));

    always_ff @(posedge clk) begin
        if (rst)             defl_cnt <= '0;
        else if (cnt_sum[16]) defl_cnt <= '1;
        else                  defl_cnt <= cnt_sum[15:0];
    end
`endif

    assign bus.nout  = out_q[PORT_N];
    assign bus.sout  = out_q[PORT_S];
    assign bus.eout  = out_q[PORT_E];
    assign bus.wout  = out_q[PORT_W];
    assign bus.eject = ej_q;
    assign bus.defl  = defl_q;

endmodule

// File: tb/tb_route_arb_stage.sv
// Scoreboard bench for route_arb_stage (MY_X=2, MY_Y=2, GOLDEN_PERIOD=8);
// directed vectors with hand-computed expected outputs.
module tb_route_arb_stage;

    typedef struct {
        logic [10:0] n, s, e, w, ej;
        logic [3:0]  df;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    route_arb_stage_if bus ();
`ifdef ROUTE_STATS_EN
    logic [15:0] defl_cnt;
`endif

    route_arb_stage #(
        .MY_X          (2),
        .MY_Y          (2),
        .GOLDEN_PERIOD (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ROUTE_STATS_EN
        ,
        .defl_cnt (defl_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q [$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_cnt = '0;

    localparam logic [3:0] MN = 4'b1000, MS = 4'b0100, ME = 4'b0010, MW = 4'b0001, M0 = 4'b0000;

    function automatic logic [10:0] fl(input int dx, input int dy);
        return {1'b1, 4'b0000, 3'(dx), 3'(dy)};
    endfunction

    function automatic logic [10:0] ow(input logic [3:0] m, input int dx, input int dy);
        return {1'b1, m, 3'(dx), 3'(dy)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at negedge and queue what must appear after the edge
    task automatic step(input logic r,
                        input logic [10:0] ni, input logic [10:0] si,
                        input logic [10:0] ei, input logic [10:0] wi,
                        input logic [10:0] en, input logic [10:0] es,
                        input logic [10:0] ee, input logic [10:0] ew,
                        input logic [10:0] ej, input logic [3:0] df);
        exp_t x;
        logic [16:0] sum;
        rst = r;
        bus.noin = ni; bus.soin = si; bus.eoin = ei; bus.woin = wi;
        if (r) begin
            model_cnt = '0;
        end else begin
            sum = {1'b0, model_cnt} + 17'($countones(df));
            model_cnt = sum[16] ? 16'hFFFF : sum[15:0];
        end
        x.n = en; x.s = es; x.e = ee; x.w = ew; x.ej = ej; x.df = df; x.cnt = model_cnt;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'b1, 11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom),
                 '0, '0, '0, '0, '0, '0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            cur = q.pop_front();
            chk("nout",  {5'b0, bus.nout},  {5'b0, cur.n});
            chk("sout",  {5'b0, bus.sout},  {5'b0, cur.s});
            chk("eout",  {5'b0, bus.eout},  {5'b0, cur.e});
            chk("wout",  {5'b0, bus.wout},  {5'b0, cur.w});
            chk("eject", {5'b0, bus.eject}, {5'b0, cur.ej});
            chk("defl",  {12'b0, bus.defl}, {12'b0, cur.df});
`ifdef ROUTE_STATS_EN
            chk("defl_cnt", defl_cnt, cur.cnt);
`endif
        end
    end

    initial begin
        rst = 1'b1;
        bus.noin = '0; bus.soin = '0; bus.eoin = '0; bus.woin = '0;
        @(negedge clk);

        // Reset with random inputs, then idle and an invalid-marked flit
        do_reset(2);
        step(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        step(1'b0, '0, 11'b0_1111_101_010, '0, '0, '0, '0, '0, '0, '0, '0);

        // Single flits
        step(1'b0, 11'b1_0000_101_010, '0, '0, '0,
             '0, '0, 11'b1_0010_101_010, '0, '0, 4'b0000);
        step(1'b0, '0, '0, '0, fl(2, 5),
             ow(MN, 2, 5), '0, '0, '0, '0, 4'b0000);

        // E-conflict held across a golden rotation: cycles 1..8 g=0, then g=1
        do_reset(1);
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8)
                step(1'b0, fl(5, 2), fl(3, 2), '0, '0,
                     ow(ME, 3, 2), '0, ow(ME, 5, 2), '0, '0, 4'b0001);
            else
                step(1'b0, fl(5, 2), fl(3, 2), '0, '0,
                     ow(ME, 5, 2), '0, ow(ME, 3, 2), '0, '0, 4'b0001);
        end

        // Ejection conflict, mixed routes, Y contention, full load (all g=0)
        do_reset(1);
        step(1'b0, '0, '0, fl(2, 2), fl(2, 2),
             ow(M0, 2, 2), '0, '0, '0, 11'b1_0000_010_010, 4'b0001);
        step(1'b0, fl(2, 2), fl(2, 0), fl(0, 4), fl(4, 4),
             '0, ow(MS, 2, 0), ow(ME | MN, 4, 4), ow(MW | MN, 0, 4), ow(M0, 2, 2), 4'b0000);
        step(1'b0, fl(2, 5), fl(2, 5), '0, '0,
             ow(MN, 2, 5), ow(MN, 2, 5), '0, '0, '0, 4'b0010);
        for (int i = 0; i < 2; i++)
            step(1'b0, fl(5, 2), fl(6, 2), fl(7, 2), fl(3, 2),
                 ow(ME, 6, 2), ow(ME, 7, 2), ow(ME, 5, 2), ow(ME, 3, 2), '0, 4'b1011);

        step(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
